// File: rtl/inst_fetcher_pkg.sv
// Shared constants for the front end: fetch FSM encoding, reset PC default,
// ROB tag width and op-type codes used by the decoder/ROB.
package inst_fetcher_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned ROB_BIT          = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    READY    = 2'd3
  } fetch_state_e;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JAL    = 3'd4,
    OP_JALR   = 3'd5
  } op_type_e;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher_align.sv
// Halfword alignment: picks the instruction at pc[1] out of the low word and,
// for a 32-bit form straddling the word boundary, the following word.
module fetch_align (
  input  logic        pc1,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] inst,
  output logic        is_32bit,
  output logic        need_hi
);

  logic [15:0] half;

  always_comb begin
    half     = pc1 ? lo_word[31:16] : lo_word[15:0];
    is_32bit = (half[1:0] == 2'b11);
    need_hi  = pc1 && is_32bit;
    if (!is_32bit)
      inst = {16'h0000, half};
    else if (pc1)
      inst = {hi_word[15:0], lo_word[31:16]};
    else
      inst = lo_word;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: fetches 16/32-bit instructions at pc and holds them for
// the decoder. Optional single-word response buffer enabled by IF_WORDBUF_EN.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        start_decode,
  input  logic        issue_signal,
  input  logic [31:0] next_pc,
  input  logic        jalr_stall,
  input  logic        wrong_predicted,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_data
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, inst_q, inst_d, inst_addr_q, inst_addr_d;
  logic [31:0]  mem_addr_q, mem_addr_d, lo_q, lo_d;
  logic         start_decode_q, start_decode_d, mem_req_q, mem_req_d, disc_q, disc_d;

  logic         resp, in_fetch, buf_now, word_ok, launch, launch_hit;
  logic [31:0]  avail_word, buf_word, pc_plus2, launch_addr, align_lo, align_inst;
  logic         align_need_hi, align_is32_unused;

  assign resp       = mem_req_q && mem_resp_valid;
  assign in_fetch   = (state_q == FETCH_LO) || (state_q == FETCH_HI);
  // A fetch phase with no request in flight is being served from the buffer.
  assign buf_now    = in_fetch && !mem_req_q;
  assign word_ok    = in_fetch && !disc_q && (resp || buf_now);
  assign avail_word = mem_req_q ? mem_data : buf_word;
  assign pc_plus2   = pc_q + 32'd2;
  assign align_lo   = (state_q == FETCH_HI) ? lo_q : avail_word;

  fetch_align u_align (
    .pc1      (pc_q[1]),
    .lo_word  (align_lo),
    .hi_word  (avail_word),
    .inst     (align_inst),
    .is_32bit (align_is32_unused),
    .need_hi  (align_need_hi)
  );

`ifdef IF_WORDBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (rdy_in) begin
      if (wrong_predicted) begin
        buf_valid_d = 1'b0;
      end else if (resp && !disc_q) begin
        buf_valid_d = 1'b1;
        buf_tag_d   = mem_addr_q[31:2];
        buf_data_d  = mem_data;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Lookup against the post-update buffer so a lo-word write never aliases the hi lookup.
  assign buf_word   = buf_data_q;
  assign launch_hit = buf_valid_d && (buf_tag_d == launch_addr[31:2]);
`else
  assign buf_word   = '0;
  assign launch_hit = 1'b0;
`endif

  always_comb begin
    launch      = 1'b0;
    launch_addr = word_addr(pc_q);
    if (wrong_predicted) begin
      launch      = !mem_req_q || resp;
      launch_addr = word_addr(next_pc);
    end else if (disc_q) begin
      launch      = resp;
      launch_addr = word_addr(pc_q);
    end else begin
      unique case (state_q)
        IDLE:     launch = 1'b1;
        FETCH_LO: begin
          launch      = word_ok && align_need_hi;
          launch_addr = word_addr(pc_plus2);
        end
        READY: begin
          launch      = issue_signal && !jalr_stall;
          launch_addr = word_addr(next_pc);
        end
        default: launch = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      if (wrong_predicted) begin
        state_d = FETCH_LO;
      end else begin
        unique case (state_q)
          IDLE:     state_d = FETCH_LO;
          FETCH_LO: if (word_ok) state_d = align_need_hi ? FETCH_HI : READY;
          FETCH_HI: if (word_ok) state_d = READY;
          READY:    if (issue_signal && !jalr_stall) state_d = FETCH_LO;
          default:  state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_addr_d    = inst_addr_q;
    start_decode_d = start_decode_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    lo_d           = lo_q;
    disc_d         = disc_q;
    if (rdy_in) begin
      if (launch) begin
        mem_req_d  = !launch_hit;
        mem_addr_d = launch_addr;
      end else if (resp) begin
        mem_req_d  = 1'b0;
      end
      if (wrong_predicted) begin
        pc_d           = next_pc;
        start_decode_d = 1'b0;
        disc_d         = mem_req_q && !resp;
      end else begin
        if (disc_q && resp) disc_d = 1'b0;
        if (word_ok) begin
          if (state_q == FETCH_LO && align_need_hi) begin
            lo_d = avail_word;
          end else begin
            start_decode_d = 1'b1;
            inst_d         = align_inst;
            inst_addr_d    = pc_q;
          end
        end
        if (state_q == READY && issue_signal && !jalr_stall) begin
          pc_d           = next_pc;
          start_decode_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q           <= RESET_PC;
      inst_q         <= '0;
      inst_addr_q    <= '0;
      start_decode_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      lo_q           <= '0;
      disc_q         <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      inst_addr_q    <= inst_addr_d;
      start_decode_q <= start_decode_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      lo_q           <= lo_d;
      disc_q         <= disc_d;
    end
  end

  assign inst         = inst_q;
  assign inst_addr    = inst_addr_q;
  assign start_decode = start_decode_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: table of fetch vectors plus hand sequences
// for flush, stall, freeze and word-buffer corner cases.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, issue_signal, jalr_stall, wrong_predicted;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] next_pc, mem_data = '0;
  logic [31:0] inst, inst_addr, mem_addr;
  logic        start_decode, mem_req;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        acc = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] acc_addr [$];

`ifdef IF_WORDBUF_EN
  localparam int BUF_REQS = 1;
`else
  localparam int BUF_REQS = 2;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic        use_flush;
    int          lat;
    logic [31:0] exp_inst;
    int          exp_reqs;
  } vec_t;

  vec_t vt [6];

  inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .inst            (inst),
    .inst_addr       (inst_addr),
    .start_decode    (start_decode),
    .issue_signal    (issue_signal),
    .next_pc         (next_pc),
    .jalr_stall      (jalr_stall),
    .wrong_predicted (wrong_predicted),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_resp_valid  (mem_resp_valid),
    .mem_data        (mem_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] last_addr(input int back);
    if (acc_addr.size() <= back) return 32'hDEAD_BEEF;
    return acc_addr[acc_addr.size() - 1 - back];
  endfunction

  // Handshake seen by memory: request + response + not paused.
  always @(posedge clk_in) begin
    acc = mem_req && mem_resp_valid && rdy_in && !rst_in;
    if (acc) acc_addr.push_back(mem_addr);
  end

  always @(negedge clk_in) begin
    if (rst_in) begin
      mem_resp_valid = 1'b0;
      mem_cnt        = 0;
      prev_req       = 1'b0;
    end else begin
      if (prev_req && !acc) begin
        check("req_hold", {31'd0, mem_req}, 32'd1);
        check("addr_hold", mem_addr, prev_addr);
      end
      if (acc || !mem_req) begin
        mem_resp_valid = 1'b0;
        mem_cnt        = 0;
      end
      if (mem_req && !mem_resp_valid) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_resp_valid = 1'b1;
          mem_data       = rd(mem_addr);
        end
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
    acc = 1'b0;
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic launch_fetch(input logic [31:0] pc, input logic flush);
    next_pc = pc;
    if (flush) wrong_predicted = 1'b1;
    else       issue_signal    = 1'b1;
    step();
    issue_signal    = 1'b0;
    wrong_predicted = 1'b0;
  endtask

  task automatic wait_decode(input string name, output int cyc);
    cyc = 0;
    while (!start_decode && cyc < 200) begin
      step();
      cyc++;
    end
    if (!start_decode) check({name, "_timeout"}, {31'd0, start_decode}, 32'd1);
  endtask

  initial begin
    int          cyc;
    int          n0;
    logic [31:0] w;

    rst_in = 1'b1; rdy_in = 1'b1; issue_signal = 1'b0; jalr_stall = 1'b0;
    wrong_predicted = 1'b0; next_pc = '0;

    vt[0] = '{pc:32'h0000_1000, w_lo:32'h0000_4501, w_hi:32'h0, use_flush:1'b0, lat:1, exp_inst:32'h0000_4501, exp_reqs:1};
    vt[1] = '{pc:32'h0000_1202, w_lo:32'h4581_0000, w_hi:32'h0, use_flush:1'b1, lat:2, exp_inst:32'h0000_4581, exp_reqs:1};
    vt[2] = '{pc:32'h0000_1300, w_lo:32'h00A5_0513, w_hi:32'h0, use_flush:1'b0, lat:3, exp_inst:32'h00A5_0513, exp_reqs:1};
    vt[3] = '{pc:32'h0000_1402, w_lo:32'h0513_1111, w_hi:32'hBEEF_1234, use_flush:1'b1, lat:1, exp_inst:32'h1234_0513, exp_reqs:2};
    vt[4] = '{pc:32'hFFFF_FFFE, w_lo:32'h0793_2222, w_hi:32'h7777_0004, use_flush:1'b0, lat:2, exp_inst:32'h0004_0793, exp_reqs:2};
    vt[5] = '{pc:32'h0000_1502, w_lo:32'h8082_0513, w_hi:32'h0, use_flush:1'b0, lat:1, exp_inst:32'h0000_8082, exp_reqs:1};

    // Reset state and first fetch from RESET_PC.
    mem[32'h0] = 32'h0000_0513;
    mem_lat    = 3;
    step(); step();
    check("rst_start_decode", {31'd0, start_decode}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst_in = 1'b0;
    wait_decode("s1", cyc);
    check("s1_latency", cyc, 32'd4);
    check("s1_inst", inst, 32'h0000_0513);
    check("s1_inst_addr", inst_addr, 32'd0);
    check("s1_reqs", acc_addr.size(), 32'd1);
    check("s1_req_addr", last_addr(0), 32'd0);

    // 32-bit instruction straddling a word boundary.
    mem[32'h0] = 32'h0093_4501;
    mem[32'h4] = 32'h1234_0000;
    mem_lat    = 2;
    n0 = acc_addr.size();
    launch_fetch(32'h2, 1'b1);
    wait_decode("s2", cyc);
    check("s2_inst", inst, 32'h0000_0093);
    check("s2_inst_addr", inst_addr, 32'h2);
    check("s2_reqs", acc_addr.size() - n0, 32'd2);
    check("s2_hi_addr", last_addr(0), 32'h4);

    // Issue redirects the next fetch and drops start_decode.
    mem[32'h100] = 32'h0000_0001;
    n0 = acc_addr.size();
    launch_fetch(32'h100, 1'b0);
    check("s3_start_decode_low", {31'd0, start_decode}, 32'd0);
    check("s3_mem_req", {31'd0, mem_req}, 32'd1);
    check("s3_mem_addr", mem_addr, 32'h100);
    wait_decode("s3", cyc);
    check("s3_inst", inst, 32'h0000_0001);
    check("s3_inst_addr", inst_addr, 32'h100);

    for (int i = 0; i < 6; i++) begin
      w = {vt[i].pc[31:2], 2'b00};
      mem[w] = vt[i].w_lo;
      if (vt[i].exp_reqs == 2) mem[w + 32'd4] = vt[i].w_hi;
      mem_lat = vt[i].lat;
      n0 = acc_addr.size();
      launch_fetch(vt[i].pc, vt[i].use_flush);
      wait_decode($sformatf("v%0d", i), cyc);
      check($sformatf("v%0d_inst", i), inst, vt[i].exp_inst);
      check($sformatf("v%0d_inst_addr", i), inst_addr, vt[i].pc);
      check($sformatf("v%0d_reqs", i), acc_addr.size() - n0, vt[i].exp_reqs);
      check($sformatf("v%0d_last_addr", i), last_addr(0),
            (vt[i].exp_reqs == 2) ? w + 32'd4 : w);
    end

    // jalr_stall holds READY untouched.
    jalr_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("jalr_start_decode", {31'd0, start_decode}, 32'd1);
      check("jalr_inst", inst, 32'h0000_8082);
      check("jalr_inst_addr", inst_addr, 32'h1502);
      check("jalr_mem_req", {31'd0, mem_req}, 32'd0);
    end
    jalr_stall = 1'b0;
    mem[32'h1600] = 32'h0000_0002;
    launch_fetch(32'h1600, 1'b0);
    check("jalr_adv_req", {31'd0, mem_req}, 32'd1);
    check("jalr_adv_addr", mem_addr, 32'h1600);
    wait_decode("jalr_adv", cyc);
    check("jalr_adv_inst", inst, 32'h0000_0002);

    // Flush while a request is pending: response discarded, refetch at new pc.
    mem[32'h600] = 32'h0000_4111;
    mem[32'h40]  = 32'h0000_4505;
    mem_lat      = 4;
    n0 = acc_addr.size();
    launch_fetch(32'h600, 1'b0);
    launch_fetch(32'h40, 1'b1);
    wait_decode("s5", cyc);
    check("s5_inst", inst, 32'h0000_4505);
    check("s5_inst_addr", inst_addr, 32'h40);
    check("s5_reqs", acc_addr.size() - n0, 32'd2);
    check("s5_first_addr", last_addr(1), 32'h600);
    check("s5_second_addr", last_addr(0), 32'h40);

    // Response in the same cycle as a flush is dropped.
    mem[32'h700] = 32'h0000_4222;
    mem[32'h80]  = 32'h0000_4511;
    mem_lat      = 2;
    n0 = acc_addr.size();
    launch_fetch(32'h700, 1'b0);
    cyc = 0;
    while (!mem_resp_valid && cyc < 50) begin
      step();
      cyc++;
    end
    check("s6_resp_seen", {31'd0, mem_resp_valid}, 32'd1);
    launch_fetch(32'h80, 1'b1);
    wait_decode("s6", cyc);
    check("s6_inst", inst, 32'h0000_4511);
    check("s6_inst_addr", inst_addr, 32'h80);
    check("s6_reqs", acc_addr.size() - n0, 32'd2);
    check("s6_addr", last_addr(0), 32'h80);

    // rdy_in low freezes everything, including a pending response.
    mem[32'h800] = 32'h0000_0001;
    mem_lat      = 1;
    n0 = acc_addr.size();
    launch_fetch(32'h800, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_mem_req", {31'd0, mem_req}, 32'd1);
      check("frz_mem_addr", mem_addr, 32'h800);
      check("frz_start_decode", {31'd0, start_decode}, 32'd0);
      check("frz_reqs", acc_addr.size() - n0, 32'd0);
    end
    rdy_in = 1'b1;
    wait_decode("s7", cyc);
    check("s7_inst", inst, 32'h0000_0001);
    check("s7_inst_addr", inst_addr, 32'h800);
    rdy_in = 1'b0; issue_signal = 1'b1; next_pc = 32'h900;
    for (int i = 0; i < 2; i++) begin
      step();
      check("frz_rdy_sd", {31'd0, start_decode}, 32'd1);
      check("frz_rdy_req", {31'd0, mem_req}, 32'd0);
    end
    issue_signal = 1'b0; rdy_in = 1'b1;
    step();
    check("frz_after_sd", {31'd0, start_decode}, 32'd1);
    check("frz_after_addr", inst_addr, 32'h800);

    // Two compressed instructions in one word.
    mem[32'hA00] = 32'h4581_4501;
    mem_lat      = 2;
    n0 = acc_addr.size();
    launch_fetch(32'hA00, 1'b1);
    wait_decode("s8a", cyc);
    check("s8a_inst", inst, 32'h0000_4501);
    launch_fetch(32'hA02, 1'b0);
    wait_decode("s8b", cyc);
    check("s8b_inst", inst, 32'h0000_4581);
    check("s8b_inst_addr", inst_addr, 32'hA02);
    check("s8_reqs", acc_addr.size() - n0, BUF_REQS);

    // Asynchronous reset mid-cycle.
    step();
    rst_in = 1'b1;
    #1;
    check("arst_start_decode", {31'd0, start_decode}, 32'd0);
    check("arst_inst", inst, 32'd0);
    check("arst_inst_addr", inst_addr, 32'd0);
    check("arst_mem_req", {31'd0, mem_req}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
